// File: rtl/hex_display_ctrl.sv
// Latches a DIGITS-nibble value and drives active-low 7-segment patterns, static per digit and time-multiplexed.
// All outputs registered: seg_static one cycle after data_reg, seg_mux/an_n one cycle after that; no backpressure.
module hex_display_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*4-1:0]   data,
    input  logic                  load,
    input  logic                  lzb,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS*7-1:0]   seg_static,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     an_n
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    logic [DIGITS*4-1:0]     data_q, data_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]           digit_sel_q, digit_sel_d;
    logic [DIGITS-1:0][6:0]  seg_static_q, seg_static_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic [DIGITS-1:0]       an_n_q, an_n_d;
    logic                    blink_wrap;
    logic                    scan_wrap;
    logic                    upper_nz;
    logic                    blank;

    // Returns the active-low pattern directly (table value inverted).
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return ~seg;
    endfunction

    always_comb begin
        data_d        = load ? data : data_q;

        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;

        scan_wrap     = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_sel_d   = digit_sel_q;
        if (scan_wrap) begin
            digit_sel_d = (digit_sel_q == DIGIT_LAST) ? '0 : digit_sel_q + 1'b1;
        end

        // Walk from the most significant digit down so upper_nz covers nibbles i..DIGITS-1.
        upper_nz     = 1'b0;
        blank        = 1'b0;
        seg_static_d = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (|data_q[4*i +: 4]);
            blank    = (blink_phase_q & blink_mask[i]) | (lzb & (i != 0) & ~upper_nz);
            seg_static_d[i] = blank ? 7'h7F : decode(data_q[4*i +: 4]);
        end

        seg_mux_d = seg_static_q[digit_sel_q];
        an_n_d    = ~(DIGITS'(1) << digit_sel_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            scan_cnt_q    <= '0;
            digit_sel_q   <= '0;
            seg_static_q  <= '1;
            seg_mux_q     <= 7'h7F;
            an_n_q        <= '1;
        end else begin
            data_q        <= data_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_sel_q   <= digit_sel_d;
            seg_static_q  <= seg_static_d;
            seg_mux_q     <= seg_mux_d;
            an_n_q        <= an_n_d;
        end
    end

    assign seg_static = seg_static_q;
    assign seg_mux    = seg_mux_q;
    assign an_n       = an_n_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

    localparam int ND = 4;
    localparam int SD = 3;
    localparam int BD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      data;
    logic             load;
    logic             lzb;
    logic [3:0]       blink_mask;
    logic [27:0]      seg_static;
    logic [6:0]       seg_mux;
    logic [3:0]       an_n;

    int errors = 0;
    int checks = 0;

    hex_display_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .load       (load),
        .lzb        (lzb),
        .blink_mask (blink_mask),
        .seg_static (seg_static),
        .seg_mux    (seg_mux),
        .an_n       (an_n)
    );

    always #5 clk = ~clk;

    // Active-low patterns for hex 0..F.
    logic [6:0] inv [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] exp_static(input logic [15:0] v, input logic lz,
                                               input logic [3:0] m, input logic ph);
        logic [27:0] r;
        logic        b;
        r = '1;
        for (int i = 0; i < ND; i++) begin
            b = (m[i] && ph) || (lz && i > 0 && (v >> (4*i)) == 16'h0);
            r[7*i +: 7] = b ? 7'h7F : inv[v[4*i +: 4]];
        end
        return r;
    endfunction

    // Reference model: predicts the outputs after each edge and queues them for the falling edge.
    typedef struct packed {
        logic [27:0] st;
        logic [6:0]  mx;
        logic [3:0]  an;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_data;
    int          m_bcnt, m_scnt, m_sel;
    logic        m_phase;
    logic [27:0] m_st;
    logic [6:0]  m_mx;
    logic [3:0]  m_an;

    always @(posedge clk) begin
        logic [27:0] nst;
        logic [6:0]  nmx;
        logic [3:0]  nan;
        if (!rst_n) begin
            m_data = '0; m_bcnt = 0; m_phase = 1'b0; m_scnt = 0; m_sel = 0;
            m_st = '1; m_mx = 7'h7F; m_an = 4'hF;
        end else begin
            nst = exp_static(m_data, lzb, blink_mask, m_phase);
            nmx = m_st[7*m_sel +: 7];
            nan = ~(4'b0001 << m_sel);
            if (load) m_data = data;
            if (m_bcnt == BD - 1) begin m_bcnt = 0; m_phase = ~m_phase; end
            else m_bcnt++;
            if (m_scnt == SD - 1) begin m_scnt = 0; m_sel = (m_sel == ND - 1) ? 0 : m_sel + 1; end
            else m_scnt++;
            m_st = nst; m_mx = nmx; m_an = nan;
        end
        sb.push_back('{st: m_st, mx: m_mx, an: m_an});
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_static", seg_static, e.st);
            check("sb_mux", seg_mux, e.mx);
            check("sb_an", an_n, e.an);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [15:0] v);
        data = v; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    function automatic logic [27:0] plain(input logic [15:0] v);
        return {inv[v[15:12]], inv[v[11:8]], inv[v[7:4]], inv[v[3:0]]};
    endfunction

    logic [15:0] dec_vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [3:0]  an_seq   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  mux_seq  [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        logic [27:0] held;
        logic [6:0]  s [16];
        logic [3:0]  prev_an;
        int          idx;
        bit          seen;

        rst_n = 1'b0; data = '0; load = 1'b0; lzb = 1'b0; blink_mask = '0;
        step(3);
        check("rst_static", seg_static, 28'hFFFFFFF);
        check("rst_mux", seg_mux, 7'h7F);
        check("rst_an", an_n, 4'hF);

        rst_n = 1'b1;
        step(1);
        check("first_static", seg_static, {4{7'h40}});

        // Decode, including the one-cycle gap between data_reg and seg_static.
        foreach (dec_vals[k]) begin
            held = seg_static;
            load_val(dec_vals[k]);
            check("load_lat_hold", seg_static, held);
            step(1);
            check("decode", seg_static, plain(dec_vals[k]));
        end

        data = 16'h5A5A;
        step(3);
        check("noload_static", seg_static, plain(16'hCDEF));

        lzb = 1'b1;
        load_val(16'h0050);
        step(1);
        check("lzb_0050", seg_static, {7'h7F, 7'h7F, 7'h12, 7'h40});
        load_val(16'h0000);
        step(1);
        check("lzb_0000", seg_static, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        lzb = 1'b0;
        blink_mask = 4'b0010;
        load_val(16'h1111);
        step(2);
        for (int c = 0; c < 16; c++) begin
            s[c] = seg_static[13:7];
            check("blink_other", {seg_static[27:14], seg_static[6:0]}, {3{7'h79}});
            check("blink_d1_val", 32'((s[c] == 7'h79) || (s[c] == 7'h7F)), 32'd1);
            if (c >= 4) check("blink_period", 32'(s[c] != s[c-4]), 32'd1);
            step(1);
        end

        blink_mask = '0;
        load_val(16'h1234);
        step(2);
        prev_an = an_n;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1);
            if (an_n != prev_an) seen = 1'b1;
        end
        check("scan_change_seen", 32'(seen), 32'd1);
        idx = 0;
        for (int k = 0; k < 4; k++) if (an_seq[k] == an_n) idx = k;
        for (int c = 0; c < 12; c++) begin
            check("scan_an", an_n, an_seq[(idx + c / SD) % 4]);
            check("scan_mux", seg_mux, mux_seq[(idx + c / SD) % 4]);
            step(1);
        end

        blink_mask = 4'b0010;
        step(5);
        data = 16'hFFFF; load = 1'b1; rst_n = 1'b0;
        step(1);
        check("midrst_static", seg_static, 28'hFFFFFFF);
        check("midrst_mux", seg_mux, 7'h7F);
        check("midrst_an", an_n, 4'hF);
        load = 1'b0; rst_n = 1'b1; blink_mask = '0;
        step(1);
        check("midrst_d0", seg_static[6:0], 7'h40);
        check("midrst_all", seg_static, {4{7'h40}});

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
